// File: rtl/pfxsum_job_ctrl.sv
// Prefix-sum job sequencer: per-line AXI read, engine scan with running carry, AXI write.
// Optional PFXSUM_CTRL_RESP_CHECK_EN aborts the job with err=1 on a non-OKAY rresp/bresp.
module pfxsum_job_ctrl #(
  parameter int unsigned LINE_W    = 512,
  parameter logic [31:0] SR_SRC    = 32'h00,
  parameter logic [31:0] SR_DST    = 32'h08,
  parameter logic [31:0] SR_LINES  = 32'h10,
  parameter logic [31:0] SR_START  = 32'h18,
  parameter logic [31:0] SR_STATUS = 32'h20,
  parameter logic [31:0] SR_TOTAL  = 32'h28
) (
  input  logic                clk,
  input  logic                rst,
  output logic [15:0]         arid_m,
  output logic [63:0]         araddr_m,
  output logic [7:0]          arlen_m,
  output logic [2:0]          arsize_m,
  output logic                arvalid_m,
  input  logic                arready_m,
  input  logic [LINE_W-1:0]   rdata_m,
  input  logic [1:0]          rresp_m,
  input  logic                rlast_m,
  input  logic                rvalid_m,
  output logic                rready_m,
  output logic [15:0]         awid_m,
  output logic [63:0]         awaddr_m,
  output logic [7:0]          awlen_m,
  output logic [2:0]          awsize_m,
  output logic                awvalid_m,
  input  logic                awready_m,
  output logic [LINE_W-1:0]   wdata_m,
  output logic [LINE_W/8-1:0] wstrb_m,
  output logic                wlast_m,
  output logic                wvalid_m,
  input  logic                wready_m,
  input  logic [1:0]          bresp_m,
  input  logic                bvalid_m,
  output logic                bready_m,
  output logic                eng_start,
  output logic [LINE_W-1:0]   eng_vec,
  output logic [63:0]         eng_carry,
  input  logic                eng_done,
  input  logic [LINE_W-1:0]   eng_result,
  input  logic [63:0]         eng_sum,
  input  logic                softreg_req_valid,
  input  logic                softreg_req_isWrite,
  input  logic [31:0]         softreg_req_addr,
  input  logic [63:0]         softreg_req_data,
  output logic                softreg_resp_valid,
  output logic [63:0]         softreg_resp_data
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, SCAN, WR, WR_B, NEXT, DONE} state_t;

  state_t            state;
  logic [63:0]       src_cfg, dst_cfg, lines_cfg;
  logic [63:0]       cur_src, cur_dst, remaining;
  logic [63:0]       carry, total;
  logic              busy, done, err;
  logic [LINE_W-1:0] line_buf;
  logic [63:0]       rd_data;
  logic              cfg_wr, start_req, aw_fire, w_fire;
  logic              resp_bad_r, resp_bad_b;
  logic              resp_unused;

  assign arid_m    = '0;
  assign arlen_m   = '0;
  assign arsize_m  = 3'b110;
  assign araddr_m  = cur_src;
  assign awid_m    = '0;
  assign awlen_m   = '0;
  assign awsize_m  = 3'b110;
  assign awaddr_m  = cur_dst;
  assign wdata_m   = line_buf;
  assign wstrb_m   = '1;
  assign wlast_m   = 1'b1;
  assign eng_vec   = line_buf;
  assign eng_carry = carry;

  assign cfg_wr    = softreg_req_valid && softreg_req_isWrite && !busy;
  assign start_req = cfg_wr && (softreg_req_addr == SR_START);
  assign aw_fire   = awvalid_m && awready_m;
  assign w_fire    = wvalid_m && wready_m;

`ifdef PFXSUM_CTRL_RESP_CHECK_EN
  assign resp_bad_r = (rresp_m != 2'b00);
  assign resp_bad_b = (bresp_m != 2'b00);
`else
  assign resp_bad_r = 1'b0;
  assign resp_bad_b = 1'b0;
`endif
  assign resp_unused = ^{rresp_m, bresp_m, rlast_m};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      src_cfg   <= '0;
      dst_cfg   <= '0;
      lines_cfg <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      carry     <= '0;
      total     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      line_buf  <= '0;
      arvalid_m <= 1'b0;
      rready_m  <= 1'b0;
      awvalid_m <= 1'b0;
      wvalid_m  <= 1'b0;
      bready_m  <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (cfg_wr) begin
        if (softreg_req_addr == SR_SRC)   src_cfg   <= softreg_req_data;
        if (softreg_req_addr == SR_DST)   dst_cfg   <= softreg_req_data;
        if (softreg_req_addr == SR_LINES) lines_cfg <= softreg_req_data;
      end
      case (state)
        IDLE: if (start_req) begin
          carry <= '0;
          done  <= 1'b0;
          err   <= 1'b0;
          if (lines_cfg == '0) begin
            state <= DONE;
          end else begin
            cur_src   <= {src_cfg[63:6], 6'b0};
            cur_dst   <= {dst_cfg[63:6], 6'b0};
            remaining <= lines_cfg;
            busy      <= 1'b1;
            arvalid_m <= 1'b1;
            state     <= RD_A;
          end
        end
        RD_A: if (arready_m) begin
          arvalid_m <= 1'b0;
          rready_m  <= 1'b1;
          state     <= RD_D;
        end
        RD_D: if (rvalid_m) begin
          rready_m <= 1'b0;
          if (resp_bad_r) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            line_buf  <= rdata_m;
            eng_start <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: if (eng_done) begin
          line_buf  <= eng_result;
          carry     <= carry + eng_sum;
          awvalid_m <= 1'b1;
          wvalid_m  <= 1'b1;
          state     <= WR;
        end
        WR: begin
          if (aw_fire) awvalid_m <= 1'b0;
          if (w_fire)  wvalid_m  <= 1'b0;
          // Each channel is finished if it fires now or already fired earlier.
          if ((aw_fire || !awvalid_m) && (w_fire || !wvalid_m)) begin
            bready_m <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: if (bvalid_m) begin
          bready_m <= 1'b0;
          if (resp_bad_b) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          cur_src   <= cur_src + 64'd64;
          cur_dst   <= cur_dst + 64'd64;
          remaining <= remaining - 64'd1;
          if (remaining == 64'd1) begin
            state <= DONE;
          end else begin
            arvalid_m <= 1'b1;
            state     <= RD_A;
          end
        end
        DONE: begin
          total <= carry;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (softreg_req_addr == SR_STATUS)     rd_data = {61'b0, err, done, busy};
    else if (softreg_req_addr == SR_TOTAL) rd_data = total;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= '0;
    end else begin
      softreg_resp_valid <= softreg_req_valid && !softreg_req_isWrite;
      softreg_resp_data  <= rd_data;
    end
  end

endmodule

// File: tb/tb_pfxsum_job_ctrl.sv
// Directed bench for pfxsum_job_ctrl with AXI slave and scan-engine responders.
module tb_pfxsum_job_ctrl;
  localparam int LW = 512;
  localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h08, A_LINES = 32'h10;
  localparam logic [31:0] A_START = 32'h18, A_STATUS = 32'h20, A_TOTAL = 32'h28;

  logic clk, rst;
  logic [15:0] arid_m, awid_m;
  logic [63:0] araddr_m, awaddr_m;
  logic [7:0] arlen_m, awlen_m;
  logic [2:0] arsize_m, awsize_m;
  logic arvalid_m, arready_m, rlast_m, rvalid_m, rready_m;
  logic awvalid_m, awready_m, wlast_m, wvalid_m, wready_m, bvalid_m, bready_m;
  logic [LW-1:0] rdata_m, wdata_m, eng_vec, eng_result;
  logic [LW/8-1:0] wstrb_m;
  logic [1:0] rresp_m, bresp_m;
  logic eng_start, eng_done;
  logic [63:0] eng_carry, eng_sum;
  logic req_valid, req_write, resp_valid;
  logic [31:0] req_addr;
  logic [63:0] req_data, resp_data;

  int n_cmp = 0, n_fail = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, st_cnt = 0, bad_cnt = 0;
  logic [63:0] ar_addr [64];
  logic [63:0] aw_addr [64];
  logic [63:0] st_carry [64];
  logic [LW-1:0] st_vec [64];
  logic [LW-1:0] w_data [64];
  int wr_mode = 0;
  logic [1:0] rresp_knob = 2'b00, bresp_knob = 2'b00;
  logic [63:0] sum_knob = 64'h10;

  pfxsum_job_ctrl dut (
    .clk(clk), .rst(rst),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
    .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
    .awvalid_m(awvalid_m), .awready_m(awready_m),
    .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m), .wvalid_m(wvalid_m), .wready_m(wready_m),
    .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
    .eng_start(eng_start), .eng_vec(eng_vec), .eng_carry(eng_carry),
    .eng_done(eng_done), .eng_result(eng_result), .eng_sum(eng_sum),
    .softreg_req_valid(req_valid), .softreg_req_isWrite(req_write),
    .softreg_req_addr(req_addr), .softreg_req_data(req_data),
    .softreg_resp_valid(resp_valid), .softreg_resp_data(resp_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Handshake monitor
  always @(posedge clk) begin
    if (arvalid_m && arready_m) begin
      ar_addr[ar_cnt % 64] <= araddr_m;
      ar_cnt <= ar_cnt + 1;
      if (arlen_m != 0 || arsize_m != 3'b110 || arid_m != 0) bad_cnt <= bad_cnt + 1;
    end
    if (rvalid_m && rready_m) r_cnt <= r_cnt + 1;
    if (awvalid_m && awready_m) begin
      aw_addr[aw_cnt % 64] <= awaddr_m;
      aw_cnt <= aw_cnt + 1;
    end
    if (wvalid_m && wready_m) begin
      w_data[w_cnt % 64] <= wdata_m;
      w_cnt <= w_cnt + 1;
    end
    if (bvalid_m && bready_m) b_cnt <= b_cnt + 1;
    if (eng_start) begin
      st_carry[st_cnt % 64] <= eng_carry;
      st_vec[st_cnt % 64] <= eng_vec;
      st_cnt <= st_cnt + 1;
    end
  end

  // AXI slave and scan-engine responders, driven on the falling edge
  initial begin
    int eng_cnt, awwait;
    eng_cnt = 0; awwait = 0;
    arready_m = 0; rvalid_m = 0; rdata_m = '0; rresp_m = 0; rlast_m = 0;
    awready_m = 0; wready_m = 0; bvalid_m = 0; bresp_m = 0;
    eng_done = 0; eng_result = '0; eng_sum = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready_m = 0; rvalid_m = 0; awready_m = 0; wready_m = 0; bvalid_m = 0;
        eng_done = 0; eng_cnt = 0; awwait = 0;
      end else begin
        arready_m = arvalid_m;
        rvalid_m = (ar_cnt > r_cnt);
        rlast_m = rvalid_m;
        if (rvalid_m) rdata_m = {8{ar_addr[(ar_cnt - 1) % 64]}};
        rresp_m = rresp_knob;
        awwait = awvalid_m ? awwait + 1 : 0;
        awready_m = awvalid_m && (wr_mode == 0 || awwait >= 4);
        wready_m = wvalid_m;
        bvalid_m = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
        bresp_m = bresp_knob;
        eng_done = 0;
        if (eng_start) eng_cnt = 3;
        else if (eng_cnt > 0) begin
          eng_cnt = eng_cnt - 1;
          if (eng_cnt == 0) begin
            eng_done = 1; eng_result = ~eng_vec; eng_sum = sum_knob;
          end
        end
      end
    end
  end

  task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 0; req_write = 0;
  endtask

  task automatic sr_read(input logic [31:0] a, output logic [63:0] d, output logic v);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = a;
    @(negedge clk);
    req_valid = 0;
    v = resp_valid; d = resp_data;
  endtask

  task automatic start_job(input logic [63:0] s, input logic [63:0] dd, input logic [63:0] n);
    sr_write(A_SRC, s);
    sr_write(A_DST, dd);
    sr_write(A_LINES, n);
    sr_write(A_START, 64'h1);
  endtask

  task automatic wait_done(output bit ok);
    logic [63:0] d; logic v;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      sr_read(A_STATUS, d, v);
      if (v && d[1:0] == 2'b10) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset;
    logic [63:0] d; logic v;
    rst = 0; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, eng_start, resp_valid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0",
        {arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, eng_start, resp_valid});
    end
    rst = 1;
    sr_read(A_STATUS, d, v);
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=1", v); end
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_total got=%h exp=0", d); end
  endtask

  task automatic test_zero_lines;
    logic [63:0] d; logic v; int ar0;
    ar0 = ar_cnt;
    start_job(64'h500, 64'h600, 64'h0);
    @(negedge clk);
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h2) begin n_fail++; $display("FAIL zero_status got=%h exp=2", d); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL zero_total got=%h exp=0", d); end
    repeat (10) @(negedge clk);
    n_cmp++; if (ar_cnt - ar0 !== 0) begin n_fail++; $display("FAIL zero_ar got=%0d exp=0", ar_cnt - ar0); end
  endtask

  task automatic test_three_lines;
    logic [63:0] d, ea; logic v; bit ok; int ar0, aw0, st0, w0;
    logic [LW-1:0] ev;
    ar0 = ar_cnt; aw0 = aw_cnt; st0 = st_cnt; w0 = w_cnt;
    wr_mode = 0; sum_knob = 64'h10;
    start_job(64'h1000, 64'h2000, 64'd3);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL three_done got=timeout exp=done"); end
    n_cmp++; if (ar_cnt - ar0 !== 3) begin n_fail++; $display("FAIL three_ar_count got=%0d exp=3", ar_cnt - ar0); end
    n_cmp++; if (aw_cnt - aw0 !== 3) begin n_fail++; $display("FAIL three_aw_count got=%0d exp=3", aw_cnt - aw0); end
    for (int i = 0; i < 3; i++) begin
      ea = 64'h1000 + 64'h40 * i;
      n_cmp++; if (ar_addr[(ar0 + i) % 64] !== ea) begin
        n_fail++; $display("FAIL three_araddr%0d got=%h exp=%h", i, ar_addr[(ar0 + i) % 64], ea); end
      ea = 64'h2000 + 64'h40 * i;
      n_cmp++; if (aw_addr[(aw0 + i) % 64] !== ea) begin
        n_fail++; $display("FAIL three_awaddr%0d got=%h exp=%h", i, aw_addr[(aw0 + i) % 64], ea); end
      ea = 64'h10 * i;
      n_cmp++; if (st_carry[(st0 + i) % 64] !== ea) begin
        n_fail++; $display("FAIL three_carry%0d got=%h exp=%h", i, st_carry[(st0 + i) % 64], ea); end
    end
    ev = {8{64'h1040}};
    n_cmp++; if (st_vec[(st0 + 1) % 64] !== ev) begin
      n_fail++; $display("FAIL three_eng_vec got=%h exp=%h", st_vec[(st0 + 1) % 64][63:0], 64'h1040); end
    ev = ~{8{64'h1080}};
    n_cmp++; if (w_data[(w0 + 2) % 64] !== ev) begin
      n_fail++; $display("FAIL three_wdata got=%h exp=%h", w_data[(w0 + 2) % 64][63:0], ev[63:0]); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h30) begin n_fail++; $display("FAIL three_total got=%h exp=30", d); end
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h2) begin n_fail++; $display("FAIL three_status got=%h exp=2", d); end
    sr_read(32'h30, d, v);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL unknown_addr got=%h exp=0", d); end
    n_cmp++; if (bad_cnt !== 0) begin n_fail++; $display("FAIL ax_constants got=%0d bad exp=0", bad_cnt); end
  endtask

  task automatic test_wr_timing;
    logic [63:0] d; logic v; bit ok; int aw0, w0, b0, st0;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    wr_mode = 1; sum_knob = 64'h100;
    start_job(64'h4000, 64'h5000, 64'd2);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wlead_done got=timeout exp=done"); end
    n_cmp++; if (aw_cnt - aw0 !== 2) begin n_fail++; $display("FAIL wlead_aw got=%0d exp=2", aw_cnt - aw0); end
    n_cmp++; if (w_cnt - w0 !== 2) begin n_fail++; $display("FAIL wlead_w got=%0d exp=2", w_cnt - w0); end
    n_cmp++; if (b_cnt - b0 !== 2) begin n_fail++; $display("FAIL wlead_b got=%0d exp=2", b_cnt - b0); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h200) begin n_fail++; $display("FAIL wlead_total got=%h exp=200", d); end
    aw0 = aw_cnt; w0 = w_cnt; st0 = st_cnt;
    wr_mode = 0; sum_knob = 64'hFFFF_FFFF_FFFF_FFFF;
    start_job(64'h4000, 64'h5000, 64'd2);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL same_done got=timeout exp=done"); end
    n_cmp++; if (aw_cnt - aw0 !== 2 || w_cnt - w0 !== 2) begin
      n_fail++; $display("FAIL same_aw_w got=%0d/%0d exp=2/2", aw_cnt - aw0, w_cnt - w0); end
    n_cmp++; if (st_carry[(st0 + 1) % 64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_carry got=%h exp=ffffffffffffffff", st_carry[(st0 + 1) % 64]); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL wrap_total got=%h exp=fffffffffffffffe", d); end
  endtask

  task automatic test_busy_writes;
    logic [63:0] d; logic v; bit ok; int ar0, st0;
    ar0 = ar_cnt; st0 = st_cnt;
    sum_knob = 64'h7;
    start_job(64'h3017, 64'h6000, 64'd2);
    sr_write(A_LINES, 64'd5);
    sr_write(A_START, 64'h1);
    sr_write(A_SRC, 64'h9000);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_done got=timeout exp=done"); end
    repeat (30) @(negedge clk);
    n_cmp++; if (ar_cnt - ar0 !== 2) begin n_fail++; $display("FAIL busy_ar got=%0d exp=2", ar_cnt - ar0); end
    n_cmp++; if (st_cnt - st0 !== 2) begin n_fail++; $display("FAIL busy_starts got=%0d exp=2", st_cnt - st0); end
    n_cmp++; if (ar_addr[(ar0 + 1) % 64] !== 64'h3040) begin
      n_fail++; $display("FAIL busy_align got=%h exp=3040", ar_addr[(ar0 + 1) % 64]); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'hE) begin n_fail++; $display("FAIL busy_total got=%h exp=e", d); end
    ar0 = ar_cnt;
    sr_write(A_START, 64'h1);
    wait_done(ok);
    n_cmp++; if (ar_cnt - ar0 !== 2 || ar_addr[ar0 % 64] !== 64'h3000) begin
      n_fail++; $display("FAIL busy_cfg_kept got=%0d@%h exp=2@3000", ar_cnt - ar0, ar_addr[ar0 % 64]); end
  endtask

  task automatic test_reset_mid_job;
    logic [63:0] d; logic v; bit ok; int ar0, aw0, st0;
    ar0 = ar_cnt; aw0 = aw_cnt; st0 = st_cnt;
    sum_knob = 64'h10;
    start_job(64'h1000, 64'h2000, 64'd3);
    for (int i = 0; i < 300 && st_cnt < st0 + 2; i++) @(negedge clk);
    n_cmp++; if (st_cnt - st0 !== 2) begin n_fail++; $display("FAIL mid_reach_scan got=%0d exp=2", st_cnt - st0); end
    rst = 0;
    #1;
    n_cmp++;
    if ({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, eng_start} !== 6'b0) begin
      n_fail++; $display("FAIL mid_valids got=%b exp=0",
        {arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, eng_start});
    end
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    n_cmp++; if (ar_cnt - ar0 !== 2 || aw_cnt - aw0 !== 1) begin
      n_fail++; $display("FAIL mid_traffic got=%0d/%0d exp=2/1", ar_cnt - ar0, aw_cnt - aw0); end
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL mid_status got=%h exp=0", d); end
    ar0 = ar_cnt;
    start_job(64'h7000, 64'h8000, 64'd1);
    wait_done(ok);
    n_cmp++; if (!ok || ar_addr[ar0 % 64] !== 64'h7000) begin
      n_fail++; $display("FAIL mid_restart got=%0d@%h exp=1@7000", ok, ar_addr[ar0 % 64]); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h10) begin n_fail++; $display("FAIL mid_total got=%h exp=10", d); end
  endtask

`ifdef PFXSUM_CTRL_RESP_CHECK_EN
  task automatic test_resp_check;
    logic [63:0] d; logic v; bit ok; int aw0, st0, ar0;
    aw0 = aw_cnt; st0 = st_cnt;
    rresp_knob = 2'b10;
    start_job(64'h1000, 64'h2000, 64'd2);
    wait_done(ok);
    rresp_knob = 2'b00;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rerr_done got=timeout exp=done"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (st_cnt - st0 !== 0 || aw_cnt - aw0 !== 0) begin
      n_fail++; $display("FAIL rerr_traffic got=%0d/%0d exp=0/0", st_cnt - st0, aw_cnt - aw0); end
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h6) begin n_fail++; $display("FAIL rerr_status got=%h exp=6", d); end
    ar0 = ar_cnt; aw0 = aw_cnt;
    bresp_knob = 2'b01; sum_knob = 64'h4;
    start_job(64'h1000, 64'h2000, 64'd2);
    wait_done(ok);
    bresp_knob = 2'b00;
    n_cmp++; if (ar_cnt - ar0 !== 1 || aw_cnt - aw0 !== 1) begin
      n_fail++; $display("FAIL berr_traffic got=%0d/%0d exp=1/1", ar_cnt - ar0, aw_cnt - aw0); end
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h6) begin n_fail++; $display("FAIL berr_status got=%h exp=6", d); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h4) begin n_fail++; $display("FAIL berr_total got=%h exp=4", d); end
  endtask
`else
  task automatic test_resp_ignored;
    logic [63:0] d; logic v; bit ok; int aw0;
    aw0 = aw_cnt;
    rresp_knob = 2'b10; bresp_knob = 2'b10; sum_knob = 64'h3;
    start_job(64'h1000, 64'h2000, 64'd1);
    wait_done(ok);
    rresp_knob = 2'b00; bresp_knob = 2'b00;
    n_cmp++; if (!ok || aw_cnt - aw0 !== 1) begin
      n_fail++; $display("FAIL resp_ignored got=%0d/%0d exp=1/1", ok, aw_cnt - aw0); end
    sr_read(A_STATUS, d, v);
    n_cmp++; if (d !== 64'h2) begin n_fail++; $display("FAIL resp_ignored_status got=%h exp=2", d); end
    sr_read(A_TOTAL, d, v);
    n_cmp++; if (d !== 64'h3) begin n_fail++; $display("FAIL resp_ignored_total got=%h exp=3", d); end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_lines;
    test_three_lines;
    test_wr_timing;
    test_busy_writes;
    test_reset_mid_job;
`ifdef PFXSUM_CTRL_RESP_CHECK_EN
    test_resp_check;
`else
    test_resp_ignored;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
